// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared word type, fetch defaults and queue entry layout.
package fetch_unit_pkg;
  typedef logic [31:0] word_t;
  localparam int FETCH_QUEUE_DEPTH = 4;
  localparam int FETCH_MAX_OUTSTANDING = 2;
  localparam word_t BOOT_ADDRESS = 32'h0000_1000;
  typedef struct packed {
    word_t data;
    word_t addr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with occupancy count and single-cycle flush.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    wr_d = flush_i ? '0 : push_i ? nxt(wr_q) : wr_q;
    rd_d = flush_i ? '0 : pop_i ? nxt(rd_q) : rd_q;
    count_d = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock)
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  assign data_o = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-based instruction fetch with in-order responses and flush-drop.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int QUEUE_DEPTH = FETCH_QUEUE_DEPTH,
  parameter int MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING
) (
  input  logic  clock,
  input  logic  reset,
  input  word_t pc_addr,
  input  logic  do_flush,
  output logic  fetch_stall,
  output logic  imem_req_valid,
  input  logic  imem_req_ready,
  output word_t imem_req_addr,
  input  logic  imem_resp_valid,
  input  word_t imem_resp_data,
  output logic  s2_valid,
  output word_t s2_instruction,
  output word_t s2_instruction_addr,
  input  logic  s2_ready
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int AW = $clog2(MAX_OUTSTANDING) + 1;
  logic [CW-1:0] occ, outs, drop_q, drop_d;
  logic [AW-1:0] af_count;
  logic accept, resp, q_push, q_pop;
  word_t af_head;
  fetch_entry_t q_head;
  // the address FIFO holds exactly the in-flight requests, so its count is the outstanding counter
  assign outs = CW'(af_count);
  always_comb begin
    imem_req_valid = ({1'b0, occ} + {1'b0, outs}) < (CW + 1)'(QUEUE_DEPTH) && outs < CW'(MAX_OUTSTANDING);
    accept = imem_req_valid && imem_req_ready;
    fetch_stall = !accept;
    imem_req_addr = pc_addr;
    resp = imem_resp_valid && outs != '0;
    q_push = resp && drop_q == '0 && !do_flush;
    s2_valid = occ != '0 && !do_flush;
    q_pop = s2_valid && s2_ready;
    s2_instruction = s2_valid ? q_head.data : '0;
    s2_instruction_addr = s2_valid ? q_head.addr : '0;
    drop_d = do_flush ? outs - CW'(resp) : resp && drop_q != '0 ? drop_q - 1'b1 : drop_q;
  end
  always_ff @(posedge clock) begin
    if (reset) drop_q <= '0;
    else drop_q <= drop_d;
  end
  fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_addr_fifo (
    .clock(clock),
    .reset(reset),
    .flush_i(1'b0),
    .push_i(accept),
    .pop_i(resp),
    .data_i(pc_addr),
    .data_o(af_head),
    .count_o(af_count)
  );
  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clock(clock),
    .reset(reset),
    .flush_i(do_flush),
    .push_i(q_push),
    .pop_i(q_pop),
    .data_i(fetch_entry_t'{data: imem_resp_data, addr: af_head}),
    .data_o(q_head),
    .count_o(occ)
  );
  a_resp_has_request: assert property (@(posedge clock) disable iff (reset) imem_resp_valid |-> outs != '0);
  a_queue_no_overflow: assert property (@(posedge clock) disable iff (reset) q_push && !q_pop |-> occ < CW'(QUEUE_DEPTH));
endmodule
